// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data memory: funct3 codes, FSM encoding,
// and the lane-steering and extension helpers used by the controller.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } store_t;

  // Unknown load codes behave as LW, so they need word alignment too.
  function automatic logic is_misaligned(input logic we, input logic [2:0] f3,
                                         input logic [1:0] lane);
    logic half;
    logic word;
    if (we) begin
      half = (f3 == F3_SH);
      word = (f3 == F3_SW);
    end else begin
      half = (f3 == F3_LH) || (f3 == F3_LHU);
      word = !((f3 == F3_LB) || (f3 == F3_LBU) || half);
    end
    return (half && lane[0]) || (word && (lane != 2'b00));
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (f3)
      F3_LB:   return {{24{shifted[7]}}, shifted[7:0]};
      F3_LH:   return {{16{shifted[15]}}, shifted[15:0]};
      F3_LBU:  return {24'b0, shifted[7:0]};
      F3_LHU:  return {16'b0, shifted[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic store_t store_lanes(input logic [2:0] f3, input logic [1:0] lane,
                                         input logic [31:0] wdata);
    store_t s;
    s.be   = 4'b0000;
    s.data = wdata;
    case (f3)
      F3_SB: begin
        s.be   = 4'b0001 << lane;
        s.data = {4{wdata[7:0]}};
      end
      F3_SH: begin
        s.be   = lane[1] ? 4'b1100 : 4'b0011;
        s.data = {2{wdata[15:0]}};
      end
      F3_SW: s.be = 4'b1111;
      default: s.be = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dm_ram_bank.sv
// Single-port word RAM built from four byte-wide lanes; synchronous write with
// per-byte enables and a registered read port.
module dm_ram_bank #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           re,
  input  logic                           we,
  input  logic [3:0]                     be,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [31:0]                    wdata,
  output logic [31:0]                    rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] mem [DEPTH_WORDS];
      logic [7:0] rd_reg;

      always_ff @(posedge clk) begin
        if (we && be[gi]) begin
          mem[addr] <= wdata[8*gi +: 8];
        end
        if (re) begin
          rd_reg <= mem[addr];
        end
      end

      assign rdata[8*gi +: 8] = rd_reg;
    end
  endgenerate

endmodule

// File: rtl/data_mem_ctrl.sv
// MEM-stage data-memory responder: fixed-latency wait-state handshake, byte/half/word
// access with RV32I load extension, and misalignment suppression.
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req_M,
  input  logic        mem_we_M,
  input  logic [2:0]  funct3_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] write_data_M,
  output logic [31:0] read_data_M,
  output logic        stall_M,
  output logic        misalign_M
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [AW-1:0] word_reg;
  logic [1:0]    lane_reg;
  logic [2:0]    f3_reg;
  logic          we_reg;
  logic [31:0]   wdata_reg;
  logic [31:0]   read_data_reg;

  logic          req_misaligned;
  logic          start;
  logic          fire;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  store_t        store_s;
  logic          addr_unused;

  // Address bits above the memory size are ignored, so accesses wrap.
  assign addr_unused = ^addr_M[31:AW+2];

  assign req_misaligned = is_misaligned(mem_we_M, funct3_M, addr_M[1:0]);
  assign start          = (state_reg == IDLE) && mem_req_M && !req_misaligned;
  assign fire           = (state_reg == WAIT) && (cnt_reg == '0);

  assign misalign_M  = (state_reg == IDLE) && mem_req_M && req_misaligned;
  assign stall_M     = start || (state_reg == WAIT);
  assign read_data_M = read_data_reg;

  // The read is launched as the request is accepted; the word then sits in the
  // RAM output register for the whole WAIT phase.
  assign ram_addr = (state_reg == IDLE) ? addr_M[AW+1:2] : word_reg;
  assign store_s  = store_lanes(f3_reg, lane_reg, wdata_reg);

  dm_ram_bank #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .re    (start && !mem_we_M),
    .we    (fire && we_reg),
    .be    (store_s.be),
    .addr  (ram_addr),
    .wdata (store_s.data),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = WAIT;
          cnt_next   = CW'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      word_reg      <= '0;
      lane_reg      <= '0;
      f3_reg        <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      read_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (start) begin
        word_reg  <= addr_M[AW+1:2];
        lane_reg  <= addr_M[1:0];
        f3_reg    <= funct3_M;
        we_reg    <= mem_we_M;
        wdata_reg <= write_data_M;
      end
      if (fire && !we_reg) begin
        read_data_reg <= load_extend(f3_reg, lane_reg, ram_rdata);
      end
    end
  end

endmodule
